commit_trace_buffer: RTL and testbench

Producer side of the retire trace stream. Sits between the superscalar commit stage and any trace sink (log writer, lock-step golden-model comparator). Accepts up to IssueWidth retired-instruction records per cycle, buffers them in program order, and emits them one record per cycle over a valid/ready port. A sink therefore never needs to know the issue width.

---
 rtl/commit_trace_buffer.sv | 177 +++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// commit_trace_buffer
//
// Producer side of the retire trace stream. Takes up to IssueWidth retired
// instruction records per cycle from the commit stage, keeps them in program
// order in a small circular FIFO and hands them out one per cycle over a
// valid/ready port, so a trace sink never has to know the issue width.
//
// Ports
//   clk_i, rst_i        clock (rising edge) and synchronous active-high reset
//   update_i            per-lane retire valid, lane 0 is the oldest
//   pc_i .. mem_wrt_i   per-lane retire record fields
//   ready_o             room for a full retire group this cycle
//   trace_valid_o       head record valid
//   trace_ready_i       sink accepts the head record
//   trace_*_o           head record fields (all zero when nothing is valid)
//   trace_seq_o         retire sequence number of the head record
//   count_o             number of occupied entries
//   overflow_o          sticky flag: a retire group was dropped
// ---------------------------------------------------------------------------
module commit_trace_buffer #(
    parameter int IssueWidth = 2,
    parameter int XLEN       = 32,
    parameter int Depth      = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [IssueWidth-1:0]               update_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     pc_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     instr_i,
    input  logic [IssueWidth-1:0][4:0]          reg_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     reg_data_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     mem_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]     mem_data_i,
    input  logic [IssueWidth-1:0]               mem_wrt_i,
    output logic                                ready_o,
    output logic                                trace_valid_o,
    input  logic                                trace_ready_i,
    output logic [XLEN-1:0]                     trace_pc_o,
    output logic [XLEN-1:0]                     trace_instr_o,
    output logic [4:0]                          trace_reg_addr_o,
    output logic [XLEN-1:0]                     trace_reg_data_o,
    output logic [XLEN-1:0]                     trace_mem_addr_o,
    output logic [XLEN-1:0]                     trace_mem_data_o,
    output logic                                trace_mem_wrt_o,
    output logic [XLEN-1:0]                     trace_seq_o,
    output logic [$clog2(Depth):0]              count_o,
    output logic                                overflow_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    // A group is only accepted when every lane is guaranteed a slot, so the
    // highest occupancy that still takes a group is Depth - IssueWidth.
    localparam logic [CntW-1:0] ReadyLimit = CntW'(Depth - IssueWidth);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
        logic [XLEN-1:0] seq;
    } entry_t;

    entry_t          entries_q [Depth];
    entry_t          entries_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [XLEN-1:0] seq_q, seq_d;
    logic            overflow_q, overflow_d;

    logic            ready;
    logic            push_any;
    logic            accept;
    logic            pop;
    logic [CntW-1:0] n_push;
    logic [PtrW-1:0] slot;
    entry_t          head;

    // Handshake terms are built from registered state only, so a pop in the
    // same cycle never widens acceptance and there is no input-to-ready path.
    always_comb begin
        ready    = (count_q <= ReadyLimit);
        push_any = |update_i;
        accept   = push_any & ready;
        pop      = (count_q != '0) & trace_ready_i;
    end

    // Active lanes are packed densely from the write pointer in lane order;
    // n_push doubles as the slot offset and the sequence offset of each lane.
    // Fields that carry no meaning (x0 destination, non-store) are stored as
    // zero so the sink sees a canonical record.
    always_comb begin
        entries_d  = entries_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        n_push     = '0;
        slot       = '0;

        if (accept) begin
            for (int l = 0; l < IssueWidth; l++) begin
                if (update_i[l]) begin
                    slot = wr_ptr_q + n_push[PtrW-1:0];
                    entries_d[slot] = '{
                        pc:       pc_i[l],
                        instr:    instr_i[l],
                        reg_addr: reg_addr_i[l],
                        reg_data: (reg_addr_i[l] != 5'd0) ? reg_data_i[l] : '0,
                        mem_addr: mem_wrt_i[l] ? mem_addr_i[l] : '0,
                        mem_data: mem_wrt_i[l] ? mem_data_i[l] : '0,
                        mem_wrt:  mem_wrt_i[l],
                        seq:      seq_q + XLEN'(n_push)
                    };
                    n_push = n_push + CntW'(1);
                end
            end
        end

        wr_ptr_d = wr_ptr_q + n_push[PtrW-1:0];
        seq_d    = seq_q + XLEN'(n_push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + n_push - CntW'(pop);

        // A refused group is dropped whole; only the sticky flag records it.
        if (push_any && !ready) begin
            overflow_d = 1'b1;
        end
    end

    // Control state: pointers, occupancy, sequence counter and overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage needs no reset: an entry is never observed before it
    // has been written, because the outputs are gated by occupancy.
    always_ff @(posedge clk_i) begin
        entries_q <= entries_d;
    end

    // Head record comes straight from storage; zeroed while the FIFO is empty.
    always_comb begin
        head             = entries_q[rd_ptr_q];
        trace_valid_o    = (count_q != '0);
        trace_pc_o       = trace_valid_o ? head.pc       : '0;
        trace_instr_o    = trace_valid_o ? head.instr    : '0;
        trace_reg_addr_o = trace_valid_o ? head.reg_addr : '0;
        trace_reg_data_o = trace_valid_o ? head.reg_data : '0;
        trace_mem_addr_o = trace_valid_o ? head.mem_addr : '0;
        trace_mem_data_o = trace_valid_o ? head.mem_data : '0;
        trace_mem_wrt_o  = trace_valid_o ? head.mem_wrt  : 1'b0;
        trace_seq_o      = trace_valid_o ? head.seq      : '0;
        ready_o          = ready;
        count_o          = count_q;
        overflow_o       = overflow_q;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Self-checking bench for commit_trace_buffer. A queue of records stands in
// for the buffer: accepted lanes are appended in lane order, the sink takes
// from the front, and the expected head/count/ready/overflow are read off the
// queue after every clock edge.
// ---------------------------------------------------------------------------
module tb_commit_trace_buffer;

    localparam int IW  = 2;
    localparam int XL  = 32;
    localparam int DEP = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [IW-1:0]          update_i;
    logic [IW-1:0][XL-1:0]  pc_i;
    logic [IW-1:0][XL-1:0]  instr_i;
    logic [IW-1:0][4:0]     reg_addr_i;
    logic [IW-1:0][XL-1:0]  reg_data_i;
    logic [IW-1:0][XL-1:0]  mem_addr_i;
    logic [IW-1:0][XL-1:0]  mem_data_i;
    logic [IW-1:0]          mem_wrt_i;
    logic                   ready_o;
    logic                   trace_valid_o;
    logic                   trace_ready_i;
    logic [XL-1:0]          trace_pc_o;
    logic [XL-1:0]          trace_instr_o;
    logic [4:0]             trace_reg_addr_o;
    logic [XL-1:0]          trace_reg_data_o;
    logic [XL-1:0]          trace_mem_addr_o;
    logic [XL-1:0]          trace_mem_data_o;
    logic                   trace_mem_wrt_o;
    logic [XL-1:0]          trace_seq_o;
    logic [3:0]             count_o;
    logic                   overflow_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic [31:0] ma;
        logic [31:0] md;
        logic        mw;
        logic [31:0] seq;
    } rec_t;

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic       ovf;
        logic [3:0] count;
        rec_t       head;
    } view_t;

    rec_t        mq[$];
    logic [31:0] mseq;
    bit          movf;

    commit_trace_buffer #(.IssueWidth(IW), .XLEN(XL), .Depth(DEP)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .update_i         (update_i),
        .pc_i             (pc_i),
        .instr_i          (instr_i),
        .reg_addr_i       (reg_addr_i),
        .reg_data_i       (reg_data_i),
        .mem_addr_i       (mem_addr_i),
        .mem_data_i       (mem_data_i),
        .mem_wrt_i        (mem_wrt_i),
        .ready_o          (ready_o),
        .trace_valid_o    (trace_valid_o),
        .trace_ready_i    (trace_ready_i),
        .trace_pc_o       (trace_pc_o),
        .trace_instr_o    (trace_instr_o),
        .trace_reg_addr_o (trace_reg_addr_o),
        .trace_reg_data_o (trace_reg_data_o),
        .trace_mem_addr_o (trace_mem_addr_o),
        .trace_mem_data_o (trace_mem_data_o),
        .trace_mem_wrt_o  (trace_mem_wrt_o),
        .trace_seq_o      (trace_seq_o),
        .count_o          (count_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic view_t expected_view();
        view_t v;
        v       = '0;
        v.valid = (mq.size() != 0);
        v.ready = ((DEP - mq.size()) >= IW);
        v.ovf   = movf;
        v.count = 4'(mq.size());
        if (mq.size() != 0) v.head = mq[0];
        return v;
    endfunction

    function automatic view_t observed_view();
        view_t v;
        v.valid   = trace_valid_o;
        v.ready   = ready_o;
        v.ovf     = overflow_o;
        v.count   = count_o;
        v.head.pc    = trace_pc_o;
        v.head.instr = trace_instr_o;
        v.head.ra    = trace_reg_addr_o;
        v.head.rd    = trace_reg_data_o;
        v.head.ma    = trace_mem_addr_o;
        v.head.md    = trace_mem_data_o;
        v.head.mw    = trace_mem_wrt_o;
        v.head.seq   = trace_seq_o;
        return v;
    endfunction

    // Advance the reference queue with the inputs now being driven, then
    // cross the clock edge and settle 1 time unit past it.
    task automatic tick();
        bit   room;
        bit   take;
        rec_t r;
        if (rst_i) begin
            mq.delete();
            mseq = '0;
            movf = 1'b0;
        end else begin
            room = ((DEP - mq.size()) >= IW);
            take = (mq.size() != 0) && trace_ready_i;
            if (take) void'(mq.pop_front());
            if (update_i != '0) begin
                if (room) begin
                    for (int l = 0; l < IW; l++) begin
                        if (update_i[l]) begin
                            r.pc    = pc_i[l];
                            r.instr = instr_i[l];
                            r.ra    = reg_addr_i[l];
                            r.rd    = (reg_addr_i[l] == 5'd0) ? 32'd0 : reg_data_i[l];
                            r.ma    = mem_wrt_i[l] ? mem_addr_i[l] : 32'd0;
                            r.md    = mem_wrt_i[l] ? mem_data_i[l] : 32'd0;
                            r.mw    = mem_wrt_i[l];
                            r.seq   = mseq;
                            mseq    = mseq + 32'd1;
                            mq.push_back(r);
                        end
                    end
                end else begin
                    movf = 1'b1;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        update_i   = '0;
        pc_i       = '0;
        instr_i    = '0;
        reg_addr_i = '0;
        reg_data_i = '0;
        mem_addr_i = '0;
        mem_data_i = '0;
        mem_wrt_i  = '0;
    endtask

    task automatic random_lanes();
        for (int l = 0; l < IW; l++) begin
            pc_i[l]       = $urandom;
            instr_i[l]    = $urandom;
            reg_addr_i[l] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            reg_data_i[l] = $urandom;
            mem_addr_i[l] = $urandom;
            mem_data_i[l] = $urandom;
            mem_wrt_i[l]  = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        view_t obs, exp;
        rst_i         = 1'b1;
        trace_ready_i = 1'b0;
        random_lanes();
        update_i = 2'b11;
        tick();
        tick();
        rst_i = 1'b0;
        clear_inputs();
        obs = observed_view(); exp = expected_view();
        compared++;
        if (obs !== exp) begin
            $display("[TB] FAIL reset_view: got %h expected %h", obs, exp);
            mismatched++;
        end
        compared++;
        if ({trace_valid_o, ready_o, overflow_o, count_o, trace_pc_o, trace_seq_o}
            !== {1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0}) begin
            $display("[TB] FAIL reset_const: valid=%b ready=%b ovf=%b count=%0d pc=%h seq=%0d, expected 0 1 0 0 0 0",
                     trace_valid_o, ready_o, overflow_o, count_o, trace_pc_o, trace_seq_o);
            mismatched++;
        end
    endtask

    task automatic test_single_record();
        view_t obs, exp;
        clear_inputs();
        trace_ready_i = 1'b1;
        update_i      = 2'b01;
        pc_i[0]       = 32'h8000_0000;
        reg_addr_i[0] = 5'd5;
        reg_data_i[0] = 32'h1234;
        tick();
        clear_inputs();
        obs = observed_view(); exp = expected_view();
        compared++;
        if (obs !== exp) begin
            $display("[TB] FAIL single_view: got %h expected %h", obs, exp);
            mismatched++;
        end
        compared++;
        if ({trace_valid_o, trace_pc_o, trace_reg_addr_o, trace_reg_data_o, trace_seq_o}
            !== {1'b1, 32'h8000_0000, 5'd5, 32'h1234, 32'd0}) begin
            $display("[TB] FAIL single_const: valid=%b pc=%h ra=%0d rd=%h seq=%0d, expected 1 80000000 5 1234 0",
                     trace_valid_o, trace_pc_o, trace_reg_addr_o, trace_reg_data_o, trace_seq_o);
            mismatched++;
        end
        tick();
        compared++;
        if (count_o !== 4'd0 || trace_valid_o !== 1'b0) begin
            $display("[TB] FAIL single_drain: count=%0d valid=%b, expected 0 0", count_o, trace_valid_o);
            mismatched++;
        end
    endtask

    task automatic test_dual_retire();
        view_t obs, exp;
        logic [31:0] want_pc [2];
        want_pc[0] = 32'h8000_0004;
        want_pc[1] = 32'h8000_0008;
        clear_inputs();
        trace_ready_i = 1'b1;
        update_i      = 2'b11;
        pc_i[0]       = want_pc[0];
        pc_i[1]       = want_pc[1];
        reg_addr_i[0] = 5'd1;  reg_data_i[0] = 32'h11;
        reg_addr_i[1] = 5'd2;  reg_data_i[1] = 32'h22;
        tick();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            obs = observed_view(); exp = expected_view();
            compared++;
            if (obs !== exp) begin
                $display("[TB] FAIL dual_view[%0d]: got %h expected %h", k, obs, exp);
                mismatched++;
            end
            compared++;
            if (trace_pc_o !== want_pc[k] || trace_seq_o !== 32'(k + 1)) begin
                $display("[TB] FAIL dual_order[%0d]: pc=%h seq=%0d, expected %h %0d",
                         k, trace_pc_o, trace_seq_o, want_pc[k], k + 1);
                mismatched++;
            end
            tick();
        end
        compared++;
        if (count_o !== 4'd0) begin
            $display("[TB] FAIL dual_drain: count=%0d expected 0", count_o);
            mismatched++;
        end
    endtask

    task automatic test_sparse_x0();
        view_t obs, exp;
        random_lanes();
        trace_ready_i = 1'b1;
        update_i      = 2'b10;
        pc_i[1]       = 32'h8000_000C;
        reg_addr_i[1] = 5'd0;
        reg_data_i[1] = 32'hFFFF;
        mem_wrt_i[1]  = 1'b1;
        mem_addr_i[1] = 32'h8000_0010;
        mem_data_i[1] = 32'hAB;
        tick();
        clear_inputs();
        obs = observed_view(); exp = expected_view();
        compared++;
        if (obs !== exp) begin
            $display("[TB] FAIL sparse_view: got %h expected %h", obs, exp);
            mismatched++;
        end
        compared++;
        if ({trace_pc_o, trace_reg_addr_o, trace_reg_data_o, trace_mem_wrt_o, trace_mem_addr_o, trace_mem_data_o, trace_seq_o}
            !== {32'h8000_000C, 5'd0, 32'd0, 1'b1, 32'h8000_0010, 32'hAB, 32'd3}) begin
            $display("[TB] FAIL sparse_const: pc=%h ra=%0d rd=%h mw=%b ma=%h md=%h seq=%0d, expected 8000000c 0 0 1 80000010 ab 3",
                     trace_pc_o, trace_reg_addr_o, trace_reg_data_o, trace_mem_wrt_o,
                     trace_mem_addr_o, trace_mem_data_o, trace_seq_o);
            mismatched++;
        end
        tick();
    endtask

    task automatic test_overflow();
        view_t obs, exp;
        trace_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            random_lanes();
            update_i = 2'b11;
            tick();
            obs = observed_view(); exp = expected_view();
            compared++;
            if (obs !== exp) begin
                $display("[TB] FAIL fill_view[%0d]: got %h expected %h", i, obs, exp);
                mismatched++;
            end
            if (i == 3) begin
                compared++;
                if (count_o !== 4'd8 || ready_o !== 1'b0 || overflow_o !== 1'b0) begin
                    $display("[TB] FAIL full_const: count=%0d ready=%b ovf=%b, expected 8 0 0",
                             count_o, ready_o, overflow_o);
                    mismatched++;
                end
            end
        end
        clear_inputs();
        compared++;
        if (count_o !== 4'd8 || overflow_o !== 1'b1) begin
            $display("[TB] FAIL overflow_const: count=%0d ovf=%b, expected 8 1", count_o, overflow_o);
            mismatched++;
        end
        trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = observed_view(); exp = expected_view();
            compared++;
            if (obs !== exp) begin
                $display("[TB] FAIL drain_view[%0d]: got %h expected %h", i, obs, exp);
                mismatched++;
            end
        end
        // Records 4..11 were taken, the dropped group consumed no numbers.
        random_lanes();
        update_i = 2'b01;
        tick();
        clear_inputs();
        compared++;
        if (trace_seq_o !== 32'd12 || trace_valid_o !== 1'b1) begin
            $display("[TB] FAIL overflow_seq: seq=%0d valid=%b, expected 12 1", trace_seq_o, trace_valid_o);
            mismatched++;
        end
        tick();
    endtask

    task automatic test_push_pop();
        view_t obs, exp;
        rst_i = 1'b1;
        clear_inputs();
        tick();
        rst_i         = 1'b0;
        trace_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            random_lanes();
            update_i = 2'b11;
            tick();
        end
        random_lanes();
        update_i      = 2'b11;
        trace_ready_i = 1'b1;
        tick();
        clear_inputs();
        compared++;
        if (count_o !== 4'd7 || overflow_o !== 1'b0) begin
            $display("[TB] FAIL pushpop_const: count=%0d ovf=%b, expected 7 0", count_o, overflow_o);
            mismatched++;
        end
        for (int i = 0; i < 8; i++) begin
            obs = observed_view(); exp = expected_view();
            compared++;
            if (obs !== exp) begin
                $display("[TB] FAIL pushpop_view[%0d]: got %h expected %h", i, obs, exp);
                mismatched++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        view_t obs, exp;
        trace_ready_i = 1'b0;
        random_lanes(); update_i = 2'b11; tick();
        random_lanes(); update_i = 2'b11; tick();
        random_lanes(); update_i = 2'b01; tick();
        compared++;
        if (count_o !== 4'd5) begin
            $display("[TB] FAIL midreset_pre: count=%0d expected 5", count_o);
            mismatched++;
        end
        rst_i = 1'b1;
        random_lanes();
        update_i = 2'b11;
        tick();
        rst_i = 1'b0;
        clear_inputs();
        obs = observed_view(); exp = expected_view();
        compared++;
        if (obs !== exp) begin
            $display("[TB] FAIL midreset_view: got %h expected %h", obs, exp);
            mismatched++;
        end
        compared++;
        if (count_o !== 4'd0 || trace_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            $display("[TB] FAIL midreset_const: count=%0d valid=%b ovf=%b, expected 0 0 0",
                     count_o, trace_valid_o, overflow_o);
            mismatched++;
        end
        random_lanes();
        update_i = 2'b01;
        tick();
        clear_inputs();
        compared++;
        if (trace_valid_o !== 1'b1 || trace_seq_o !== 32'd0) begin
            $display("[TB] FAIL midreset_seq: valid=%b seq=%0d, expected 1 0", trace_valid_o, trace_seq_o);
            mismatched++;
        end
        trace_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_random();
        view_t obs, exp;
        int    slow;
        for (int i = 0; i < 600; i++) begin
            // Alternate between a slow sink (fills, overflows) and a fast one.
            slow = (i / 75) % 2;
            random_lanes();
            update_i      = 2'($urandom);
            trace_ready_i = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
            rst_i         = ($urandom_range(0, 149) == 0);
            tick();
            obs = observed_view(); exp = expected_view();
            compared++;
            if (obs !== exp) begin
                $display("[TB] FAIL random_view[%0d]: got %h expected %h", i, obs, exp);
                mismatched++;
            end
        end
        rst_i = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst_i         = 1'b1;
        trace_ready_i = 1'b0;
        mseq          = '0;
        movf          = 1'b0;
        clear_inputs();
        test_reset();
        test_single_record();
        test_dual_retire();
        test_sparse_x0();
        test_overflow();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
